// File: rtl/mips_pkg.sv
// Shared MIPS-side definitions: instruction word width, imem geometry and
// the state encoding of the imem loader FSM.
package mips_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int WORD_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a big-endian byte stream into 32-bit words. The first byte lands in [31:24].
// full flags the byte that completes a word, so the caller can act on the same edge.
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              full
);

  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] shreg;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (shift_en) begin
      shreg    <= {shreg[WORD_W-9:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign word_out = shreg;
  assign full     = shift_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs host bytes into words, writes them to
// consecutive imem addresses and keeps the core off imem while loading.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t   state_q, state_d;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] word_cnt_nx;
  logic            start_ok;
  logic            len_legal;
  logic            accept;
  logic            word_full;
  logic            last_word;

  assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign len_legal   = (len != '0) && (len <= DEPTH_L);
  assign accept      = in_valid && in_ready;
  assign word_cnt_nx = word_cnt + ONE_L;
  assign last_word   = (word_cnt_nx == len_q);

  assign in_ready = (state_q == ST_RECV);
  assign mem_we   = (state_q == ST_WRITE);
  assign busy     = (state_q == ST_RECV) || (state_q == ST_WRITE);

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_ok),
    .shift_en (accept),
    .byte_in  (in_data),
    .word_out (mem_wd),
    .full     (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = len_legal ? ST_RECV : ST_IDLE;
      ST_RECV:          if (word_full) state_d = ST_WRITE;
      ST_WRITE:         state_d = last_word ? ST_DONE : ST_RECV;
      default:          state_d = ST_IDLE;
    endcase
  end

  // On the final word mem_addr keeps the last address instead of stepping past it.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q    <= '0;
      word_cnt <= '0;
      mem_addr <= '0;
      checksum <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (start_ok) begin
      len_q    <= len;
      word_cnt <= '0;
      mem_addr <= '0;
      checksum <= '0;
      done     <= 1'b0;
      err      <= !len_legal;
    end else if (state_q == ST_WRITE) begin
      checksum <= checksum ^ mem_wd;
      word_cnt <= word_cnt_nx;
      if (last_word) done     <= 1'b1;
      else           mem_addr <= word_cnt_nx[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected imem writes,
// a negedge monitor pops and compares them whenever mem_we is high.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  check_cnt   = 0;
  int  pass_cnt    = 0;
  int  write_cnt   = 0;
  int  busy_cycles = 0;

  imem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cycles++;
      if (mem_we) begin
        write_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {26'd0, mem_addr, mem_wd}, 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr_data", {26'd0, mem_addr, mem_wd}, {26'd0, e.addr, e.data});
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [6:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  // Offer one byte until in_ready, then let it be taken at the next edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic load_word(input logic [5:0] addr, input logic [31:0] w, input int gap);
    wr_t e;
    e.addr = addr;
    e.data = w;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(gap);
      send_byte(w[31-8*k -: 8]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_mem_we"},   {63'd0, mem_we},   64'd0);
    check({tag, "_mem_addr"}, {58'd0, mem_addr}, 64'd0);
    check({tag, "_mem_wd"},   {32'd0, mem_wd},   64'd0);
    check({tag, "_busy"},     {63'd0, busy},     64'd0);
    check({tag, "_done"},     {63'd0, done},     64'd0);
    check({tag, "_err"},      {63'd0, err},      64'd0);
    check({tag, "_checksum"}, {32'd0, checksum}, 64'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wr0;
    int bc0;
    reset    = 1'b1;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_data  = '0;
    step(2);
    reset = 1'b0;
    check_reset_outputs("reset");

    // 1: two words back-to-back
    wr0 = write_cnt;
    bc0 = busy_cycles;
    do_start(7'd2);
    load_word(6'd0, 32'h2002_0005, 0);
    load_word(6'd1, 32'h2003_000c, 0);
    step();
    check("t1_done",     {63'd0, done},       64'd1);
    check("t1_busy",     {63'd0, busy},       64'd0);
    check("t1_checksum", {32'd0, checksum},   64'h0001_0009);
    check("t1_writes",   write_cnt - wr0,     64'd2);
    check("t1_busy_cyc", busy_cycles - bc0,   64'd10);

    // 2: gapped bytes, write latency of one cycle after the 4th byte
    wr0 = write_cnt;
    do_start(7'd1);
    check("t2_done_clr", {63'd0, done}, 64'd0);
    load_word(6'd0, 32'h8c08_0004, 2);
    check("t2_we_now",   {63'd0, mem_we},   64'd1);
    check("t2_addr_now", {58'd0, mem_addr}, 64'd0);
    step();
    check("t2_we_off",   {63'd0, mem_we},   64'd0);
    check("t2_done",     {63'd0, done},     64'd1);
    check("t2_checksum", {32'd0, checksum}, 64'h8c08_0004);
    check("t2_writes",   write_cnt - wr0,   64'd1);

    // 3: illegal lengths
    wr0 = write_cnt;
    bc0 = busy_cycles;
    do_start(7'd0);
    check("t3_len0_err",  {63'd0, err},  64'd1);
    check("t3_len0_done", {63'd0, done}, 64'd0);
    check("t3_len0_busy", {63'd0, busy}, 64'd0);
    step(3);
    do_start(7'd65);
    check("t3_len65_err",  {63'd0, err},  64'd1);
    check("t3_len65_busy", {63'd0, busy}, 64'd0);
    step(3);
    check("t3_writes",   write_cnt - wr0,   64'd0);
    check("t3_busy_cyc", busy_cycles - bc0, 64'd0);

    // 4: full depth, word i = i
    wr0 = write_cnt;
    do_start(7'd64);
    check("t4_err_clr", {63'd0, err}, 64'd0);
    for (int i = 0; i < 64; i++) load_word(i[5:0], i, 0);
    check("t4_last_addr", {58'd0, mem_addr}, 64'd63);
    check("t4_last_wd",   {32'd0, mem_wd},   64'h0000_003f);
    step(3);
    check("t4_done",      {63'd0, done},     64'd1);
    check("t4_addr_hold", {58'd0, mem_addr}, 64'd63);
    check("t4_checksum",  {32'd0, checksum}, 64'd0);
    check("t4_writes",    write_cnt - wr0,   64'd64);

    // 5: reset in the middle of a load
    wr0 = write_cnt;
    do_start(7'd3);
    load_word(6'd0, 32'h1111_2222, 0);
    send_byte(8'hab);
    send_byte(8'hcd);
    reset = 1'b1;
    step();
    check_reset_outputs("t5_reset");
    reset = 1'b0;
    check("t5_writes", write_cnt - wr0, 64'd1);
    do_start(7'd1);
    load_word(6'd0, 32'h0bad_cafe, 0);
    step();
    check("t5_done",     {63'd0, done},     64'd1);
    check("t5_checksum", {32'd0, checksum}, 64'h0bad_cafe);

    // 6: start ignored while busy, bytes held in WRITE/DONE not lost or consumed
    wr0 = write_cnt;
    do_start(7'd2);
    begin
      wr_t e;
      e.addr = 6'd0; e.data = 32'h0102_0304; exp_q.push_back(e);
      e.addr = 6'd1; e.data = 32'h0506_0708; exp_q.push_back(e);
    end
    send_byte(8'h01);
    send_byte(8'h02);
    start = 1'b1;
    len   = 7'd5;
    step();
    start = 1'b0;
    check("t6_busy_after_start", {63'd0, busy}, 64'd1);
    send_byte(8'h03);
    send_byte(8'h04);
    check("t6_ready_in_write", {63'd0, in_ready}, 64'd0);
    for (int b = 5; b <= 8; b++) send_byte(b[7:0]);
    in_valid = 1'b1;
    in_data  = 8'hff;
    step();
    check("t6_done",        {63'd0, done},     64'd1);
    check("t6_ready_done",  {63'd0, in_ready}, 64'd0);
    step(3);
    in_valid = 1'b0;
    check("t6_checksum",    {32'd0, checksum}, 64'h0404_040c);
    check("t6_addr",        {58'd0, mem_addr}, 64'd1);
    check("t6_writes",      write_cnt - wr0,   64'd2);

    step(2);
    check("scoreboard_empty", exp_q.size(), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
